// File: rtl/hms_mode_ctrl_pkg.sv
// Shared types and helpers for the HMS clock mode controller, display and counter blocks.
package hms_mode_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DIG_SEC    = 0;
  localparam int unsigned DIG_MIN    = 2;
  localparam int unsigned DIG_HOUR   = 4;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  typedef struct packed {
    logic hour;
    logic min;
    logic sec;
  } cnt_en_t;

  // Counter width for a divider that counts 0..n-1; never narrower than one bit.
  function automatic int unsigned div_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_CLOCK: return MODE_SETUP;
      MODE_SETUP: return MODE_ALARM;
      default:    return MODE_CLOCK;
    endcase
  endfunction

  function automatic pos_e next_pos(input pos_e p);
    case (p)
      POS_SEC: return POS_MIN;
      POS_MIN: return POS_HOUR;
      default: return POS_SEC;
    endcase
  endfunction

  function automatic cnt_en_t pos_onehot(input pos_e p);
    cnt_en_t en;
    en = '0;
    case (p)
      POS_SEC: en.sec  = 1'b1;
      POS_MIN: en.min  = 1'b1;
      default: en.hour = 1'b1;
    endcase
    return en;
  endfunction

  // Selected digit pair goes dark during the unlit half of the blink period.
  function automatic logic [NUM_DIGITS-1:0] blink_mask(input mode_e m, input pos_e p,
                                                       input logic lit);
    logic [NUM_DIGITS-1:0] mask;
    mask = '1;
    if (m != MODE_CLOCK && !lit) begin
      case (p)
        POS_SEC: mask[DIG_SEC +: 2]  = 2'b00;
        POS_MIN: mask[DIG_MIN +: 2]  = 2'b00;
        default: mask[DIG_HOUR +: 2] = 2'b00;
      endcase
    end
    return mask;
  endfunction

endpackage

// File: rtl/hms_mode_ctrl_if.sv
// Button, counter-status and control bundle between the HMS mode controller and its neighbours.
interface hms_mode_ctrl_if;
  import hms_mode_ctrl_pkg::*;

  logic                  i_sw0;
  logic                  i_sw1;
  logic                  i_sw2;
  logic                  i_sec_at_max;
  logic                  i_min_at_max;
  logic [1:0]            o_mode;
  logic [1:0]            o_position;
  cnt_en_t               o_time_en;
  cnt_en_t               o_alm_en;
  logic                  o_disp_sel;
  logic [NUM_DIGITS-1:0] o_blink_dig;

  modport master (
    output i_sw0, i_sw1, i_sw2, i_sec_at_max, i_min_at_max,
    input  o_mode, o_position, o_time_en, o_alm_en, o_disp_sel, o_blink_dig
  );

  modport slave (
    input  i_sw0, i_sw1, i_sw2, i_sec_at_max, i_min_at_max,
    output o_mode, o_position, o_time_en, o_alm_en, o_disp_sel, o_blink_dig
  );
endinterface

// File: rtl/hms_mode_ctrl_btn_debounce.sv
// Active-low push-button conditioner: 2-flop synchroniser, sampled stability counter, press pulse.
module hms_mode_ctrl_btn_debounce #(
  parameter int unsigned DEB_CNT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_n,
  input  logic sample,
  output logic press
);
  import hms_mode_ctrl_pkg::*;

  localparam int unsigned RUN_W = div_width(DEB_CNT);

  logic [1:0]       sync_q;
  logic             held_q;
  logic [RUN_W-1:0] run_q;
  logic             pressed_c;

  assign pressed_c = ~sync_q[1];

  // Accepted level flips only after DEB_CNT consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      held_q <= 1'b0;
      run_q  <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw_n};
      press  <= 1'b0;
      if (sample) begin
        if (pressed_c != held_q) begin
          if (run_q == RUN_W'(DEB_CNT - 1)) begin
            held_q <= pressed_c;
            run_q  <= '0;
            press  <= pressed_c;
          end else begin
            run_q <= run_q + RUN_W'(1);
          end
        end else begin
          run_q <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/hms_mode_ctrl.sv
// HMS clock mode controller: button debounce, CLOCK/SETUP/ALARM sequencing, counter enables, blink.
module hms_mode_ctrl
  import hms_mode_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned DEB_HZ   = 100,
  parameter int unsigned DEB_CNT  = 3,
  parameter int unsigned BLINK_HZ = 2
) (
  input logic            clk,
  input logic            rst,
  hms_mode_ctrl_if.slave bus
);

  localparam int unsigned SEC_N   = CLK_HZ;
  localparam int unsigned DEB_N   = CLK_HZ / DEB_HZ;
  localparam int unsigned BLINK_N = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned SEC_W   = div_width(SEC_N);
  localparam int unsigned DEB_W   = div_width(DEB_N);
  localparam int unsigned BLINK_W = div_width(BLINK_N);

  logic [DEB_W-1:0]   deb_cnt_q;
  logic [SEC_W-1:0]   sec_cnt_q;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic [BLINK_W-1:0] blink_cnt_d;
  logic               blink_on_q;
  logic               blink_on_d;
  logic               deb_tick_c;
  logic               sec_tick_c;
  logic               adjust_c;
  logic [2:0]         press;

  mode_e mode_q, mode_d;
  pos_e  pos_q, pos_d;

  cnt_en_t               time_en_q, time_en_d;
  cnt_en_t               alm_en_q, alm_en_d;
  logic                  disp_sel_q, disp_sel_d;
  logic [NUM_DIGITS-1:0] blink_dig_q, blink_dig_d;

  // Debounce sample strobe.
  assign deb_tick_c = (deb_cnt_q == DEB_W'(DEB_N - 1));

  always_ff @(posedge clk) begin
    if (rst || deb_tick_c) begin
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_q + DEB_W'(1);
    end
  end

  // 1 Hz divider, parked at zero while the time is being set.
  assign sec_tick_c = (mode_q != MODE_SETUP) && (sec_cnt_q == SEC_W'(SEC_N - 1));

  always_ff @(posedge clk) begin
    if (rst || mode_q == MODE_SETUP || sec_cnt_q == SEC_W'(SEC_N - 1)) begin
      sec_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_q + SEC_W'(1);
    end
  end

  hms_mode_ctrl_btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_sw0 (
    .clk    (clk),
    .rst    (rst),
    .sw_n   (bus.i_sw0),
    .sample (deb_tick_c),
    .press  (press[0])
  );

  hms_mode_ctrl_btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_sw1 (
    .clk    (clk),
    .rst    (rst),
    .sw_n   (bus.i_sw1),
    .sample (deb_tick_c),
    .press  (press[1])
  );

  hms_mode_ctrl_btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_sw2 (
    .clk    (clk),
    .rst    (rst),
    .sw_n   (bus.i_sw2),
    .sample (deb_tick_c),
    .press  (press[2])
  );

  // Blink phase restarts lit on any accepted press, which covers every mode change.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_on_d  = blink_on_q;
    if (|press) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_N - 1)) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  // Mode FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_CLOCK;
      pos_q  <= POS_SEC;
    end else begin
      mode_q <= mode_d;
      pos_q  <= pos_d;
    end
  end

  // Next state: sw0 has priority and swallows a coincident sw1.
  always_comb begin
    mode_d = mode_q;
    pos_d  = pos_q;
    if (press[0]) begin
      mode_d = next_mode(mode_q);
      pos_d  = POS_SEC;
    end else if (press[1] && mode_q != MODE_CLOCK) begin
      pos_d = next_pos(pos_q);
    end
  end

  assign adjust_c = press[2] & ~press[0];

  // Output decode, registered below so every enable lands one clk after its cause.
  always_comb begin
    time_en_d = '0;
    alm_en_d  = '0;
    if (sec_tick_c) begin
      time_en_d.sec  = 1'b1;
      time_en_d.min  = bus.i_sec_at_max;
      time_en_d.hour = bus.i_sec_at_max & bus.i_min_at_max;
    end
    if (adjust_c && mode_q == MODE_SETUP) begin
      time_en_d = pos_onehot(pos_q);
    end
    if (adjust_c && mode_q == MODE_ALARM) begin
      alm_en_d = pos_onehot(pos_q);
    end
    disp_sel_d  = (mode_d == MODE_ALARM);
    blink_dig_d = blink_mask(mode_d, pos_d, blink_on_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_en_q   <= '0;
      alm_en_q    <= '0;
      disp_sel_q  <= 1'b0;
      blink_dig_q <= '1;
    end else begin
      time_en_q   <= time_en_d;
      alm_en_q    <= alm_en_d;
      disp_sel_q  <= disp_sel_d;
      blink_dig_q <= blink_dig_d;
    end
  end

  assign bus.o_mode      = mode_q;
  assign bus.o_position  = pos_q;
  assign bus.o_time_en   = time_en_q;
  assign bus.o_alm_en    = alm_en_q;
  assign bus.o_disp_sel  = disp_sel_q;
  assign bus.o_blink_dig = blink_dig_q;

endmodule

// File: tb/tb_hms_mode_ctrl.sv
// Directed plus randomized bench for hms_mode_ctrl against a cycle-level behavioural model.
module tb_hms_mode_ctrl;

  localparam int CLK_HZ   = 100;
  localparam int DEB_HZ   = 10;
  localparam int DEB_CNT  = 3;
  localparam int BLINK_HZ = 2;
  localparam int DEB_P    = CLK_HZ / DEB_HZ;
  localparam int SEC_P    = CLK_HZ;
  localparam int BLINK_P  = CLK_HZ / (2 * BLINK_HZ);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hms_mode_ctrl_if hif ();

  hms_mode_ctrl #(
    .CLK_HZ   (CLK_HZ),
    .DEB_HZ   (DEB_HZ),
    .DEB_CNT  (DEB_CNT),
    .BLINK_HZ (BLINK_HZ)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: values the DUT outputs should hold after each edge.
  int         m_cyc, m_sec_age, m_blink_age, m_mode, m_pos;
  int         m_run [3];
  logic [2:0] m_h1, m_h2, m_acc, m_press, m_time_en, m_alm_en;
  logic       m_disp;
  logic [5:0] m_blink;

  int n_time7, n_time1, n_time2, n_time_any, n_both;

  task automatic model_edge();
    logic [2:0] raw, p;
    bit         deb_tick, sec_tick, lit, pr;
    int         old_mode, old_pos;
    if (rst) begin
      m_cyc = 0; m_sec_age = 0; m_blink_age = 0; m_mode = 0; m_pos = 0;
      m_h1 = 3'b111; m_h2 = 3'b111; m_acc = 3'b000; m_press = 3'b000;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
      m_time_en = 3'b000; m_alm_en = 3'b000; m_disp = 1'b0; m_blink = 6'h3F;
    end else begin
      raw      = {hif.i_sw2, hif.i_sw1, hif.i_sw0};
      p        = m_press;
      old_mode = m_mode;
      old_pos  = m_pos;
      deb_tick = (m_cyc % DEB_P) == DEB_P - 1;
      sec_tick = (old_mode != 1) && (m_sec_age == SEC_P - 1);
      m_time_en = 3'b000;
      m_alm_en  = 3'b000;
      if (sec_tick) m_time_en = {hif.i_sec_at_max & hif.i_min_at_max, hif.i_sec_at_max, 1'b1};
      if (p[2] && !p[0]) begin
        if (old_mode == 1) m_time_en = 3'(1 << old_pos);
        else if (old_mode == 2) m_alm_en = 3'(1 << old_pos);
      end
      if (p[0]) begin
        m_mode = (old_mode + 1) % 3;
        m_pos  = 0;
      end else if (p[1] && old_mode != 0) begin
        m_pos = (old_pos + 1) % 3;
      end
      m_disp      = (m_mode == 2);
      m_sec_age   = (old_mode == 1) ? 0 : (m_sec_age + 1) % SEC_P;
      m_blink_age = (p != 3'b000) ? 0 : m_blink_age + 1;
      lit         = ((m_blink_age / BLINK_P) % 2) == 0;
      m_blink     = 6'h3F;
      if (m_mode != 0 && !lit) m_blink = 6'(63 & ~(3 << (2 * m_pos)));
      m_press = 3'b000;
      if (deb_tick) begin
        for (int b = 0; b < 3; b++) begin
          pr = !m_h2[b];
          if (pr != m_acc[b]) begin
            m_run[b]++;
            if (m_run[b] == DEB_CNT) begin
              m_acc[b]   = pr;
              m_run[b]   = 0;
              m_press[b] = pr;
            end
          end else begin
            m_run[b] = 0;
          end
        end
      end
      m_h2 = m_h1;
      m_h1 = raw;
      m_cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("mode",      {6'b0, hif.o_mode},      8'(m_mode));
    chk("position",  {6'b0, hif.o_position},  8'(m_pos));
    chk("time_en",   {5'b0, hif.o_time_en},   {5'b0, m_time_en});
    chk("alm_en",    {5'b0, hif.o_alm_en},    {5'b0, m_alm_en});
    chk("disp_sel",  {7'b0, hif.o_disp_sel},  {7'b0, m_disp});
    chk("blink_dig", {2'b0, hif.o_blink_dig}, {2'b0, m_blink});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (hif.o_time_en == 3'b111) n_time7++;
    if (hif.o_time_en == 3'b001) n_time1++;
    if (hif.o_time_en == 3'b010) n_time2++;
    if (hif.o_time_en != 3'b000) n_time_any++;
    if (hif.o_alm_en == 3'b100 && hif.o_time_en == 3'b001) n_both++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_sw(input int b, input logic v);
    case (b)
      0:       hif.i_sw0 = v;
      1:       hif.i_sw1 = v;
      default: hif.i_sw2 = v;
    endcase
  endtask

  task automatic press(input int b);
    set_sw(b, 1'b0);
    run(40);
    set_sw(b, 1'b1);
    run(40);
  endtask

  int         hold [3];
  logic [2:0] lvl;

  initial begin
    // Reset from a random input state.
    rst = 1'b1;
    hif.i_sw0 = 1'($urandom); hif.i_sw1 = 1'($urandom); hif.i_sw2 = 1'($urandom);
    hif.i_sec_at_max = 1'($urandom); hif.i_min_at_max = 1'($urandom);
    run(2);
    chk("rst_mode",  {6'b0, hif.o_mode},      8'h00);
    chk("rst_pos",   {6'b0, hif.o_position},  8'h00);
    chk("rst_time",  {5'b0, hif.o_time_en},   8'h00);
    chk("rst_alm",   {5'b0, hif.o_alm_en},    8'h00);
    chk("rst_blink", {2'b0, hif.o_blink_dig}, 8'h3F);
    hif.i_sw0 = 1'b1; hif.i_sw1 = 1'b1; hif.i_sw2 = 1'b1;
    hif.i_sec_at_max = 1'b1; hif.i_min_at_max = 1'b1;
    rst = 1'b0;

    // Timekeeping with full and partial carry.
    n_time7 = 0;
    run(250);
    chk("tick_full_carry", 8'(n_time7), 8'd2);
    hif.i_sec_at_max = 1'b0;
    n_time1 = 0;
    run(100);
    chk("tick_sec_only", 8'(n_time1), 8'd1);

    // Long hold gives one step; a glitchy button aliased to released gives none.
    set_sw(0, 1'b0); run(60); set_sw(0, 1'b1); run(40);
    chk("sw0_hold", {6'b0, hif.o_mode}, 8'd1);
    for (int i = 0; i < DEB_P && (m_cyc % DEB_P) != 0; i++) step();
    repeat (10) begin
      set_sw(0, 1'b0); run(5);
      set_sw(0, 1'b1); run(5);
    end
    run(40);
    chk("sw0_glitch", {6'b0, hif.o_mode}, 8'd1);
    press(0); chk("seq_alarm", {6'b0, hif.o_mode}, 8'd2);
    press(0); chk("seq_clock", {6'b0, hif.o_mode}, 8'd0);
    press(0); chk("seq_setup", {6'b0, hif.o_mode}, 8'd1);

    // SETUP adjust and frozen time.
    press(1); chk("setup_pos_min", {6'b0, hif.o_position}, 8'd1);
    n_time2 = 0;
    press(2); chk("setup_adj_min", 8'(n_time2), 8'd1);
    n_time_any = 0;
    run(300); chk("setup_frozen", 8'(n_time_any), 8'd0);

    // ALARM adjust coinciding with a 1 Hz tick.
    press(0); chk("alarm_disp_sel", {7'b0, hif.o_disp_sel}, 8'd1);
    press(1); press(1); chk("alarm_pos_hour", {6'b0, hif.o_position}, 8'd2);
    n_both = 0;
    repeat (6) press(2);
    chk("alarm_tick_coincide", 8'(n_both > 0), 8'd1);

    // Blink phase in SETUP pos SEC.
    press(0);
    set_sw(0, 1'b0);
    for (int i = 0; i < 60 && hif.o_mode !== 2'd1; i++) step();
    chk("blink_enter_setup", {6'b0, hif.o_mode},      8'd1);
    chk("blink_start_lit",   {2'b0, hif.o_blink_dig}, 8'h3F);
    run(25); chk("blink_dark", {2'b0, hif.o_blink_dig}, 8'h3C);
    run(25); chk("blink_lit",  {2'b0, hif.o_blink_dig}, 8'h3F);
    set_sw(0, 1'b1); run(40);
    press(2);

    // sw0 and sw1 accepted together.
    press(1);
    hif.i_sw0 = 1'b0; hif.i_sw1 = 1'b0; run(40);
    hif.i_sw0 = 1'b1; hif.i_sw1 = 1'b1; run(40);
    chk("coinc_mode", {6'b0, hif.o_mode},     8'd2);
    chk("coinc_pos",  {6'b0, hif.o_position}, 8'd0);

    // Reset mid-operation from SETUP pos HOUR.
    press(0); press(0); press(1); press(1);
    chk("pre_rst_pos", {6'b0, hif.o_position}, 8'd2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_mode",  {6'b0, hif.o_mode},      8'd0);
    chk("mid_rst_pos",   {6'b0, hif.o_position},  8'd0);
    chk("mid_rst_blink", {2'b0, hif.o_blink_dig}, 8'h3F);

    // Randomized buttons, carries and occasional reset.
    lvl = 3'b111;
    for (int b = 0; b < 3; b++) hold[b] = 0;
    repeat (1500) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = ~lvl[b];
          set_sw(b, lvl[b]);
          hold[b] = int'($urandom_range(60, 1));
        end
        hold[b]--;
      end
      hif.i_sec_at_max = 1'($urandom);
      hif.i_min_at_max = 1'($urandom);
      rst = ($urandom_range(399, 0) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
